rtc_bus_ctrl: RTL
=================

Name: rtc_bus_ctrl

Overview:
- Downstream consumer of the PicoBlaze port decoder outputs (actRTC, dir, out_port, writestrobe, read_strobe).
- Turns microcontroller port writes into timed multiplexed address/data bus cycles to the external RTC.
- Returns RTC read data and status on in_portRTC.
- Micro flow: write ADDR, write WDATA or RDREQ, poll STATUS until not busy, then read RDATA.

Parameters:
SETUP_CYC, 2, cycles ad_out/A-D are stable before the strobe falls in each phase
STROBE_CYC, 10, cycles the strobe (wr_n or rd_n) is held low
HOLD_CYC, 2, cycles after the strobe rises before the phase ends; cs_n stays low

Ports:
clk  in  1  system clock; all logic on rising edge
kcpsm6_reset  in  1  asynchronous, active-high reset
act_rtc  in  1  decoder select for the RTC port range
dir  in  8  decoded local address; only dir[1:0] used (00 ADDR, 01 WDATA/RDATA, 10 RDREQ, 11 STATUS)
out_port  in  8  micro write data
writestrobe  in  1  micro write strobe (normal or constant write), 1-cycle pulse
read_strobe  in  1  micro read strobe, 1-cycle pulse
in_portRTC  out  8  registered read-back mux to micro
rtc_cs_n  out  1  RTC chip select, active low
rtc_rd_n  out  1  RTC read strobe, active low
rtc_wr_n  out  1  RTC write strobe, active low
rtc_ad  out  1  0 = address phase, 1 = data phase
rtc_ad_out  out  8  bus drive value
rtc_ad_oe  out  1  1 = drive bus (top-level tristate)
rtc_ad_in  in  8  bus sampled value

Behaviour:
Reset values:
- rtc_cs_n = rtc_rd_n = rtc_wr_n = 1; rtc_ad = 0; rtc_ad_oe = 0; rtc_ad_out = 0.
- in_portRTC = 0; ADDR = RDATA = WDATA = 0; busy = 0; err = 0; FSM = IDLE.
- Reset is asynchronous and takes effect mid-cycle: strobes release immediately, any bus cycle in progress is aborted, and no RDATA update occurs.

Register access:
- Accesses count only when act_rtc = 1.
- Write to ADDR latches out_port into ADDR.
- Write to WDATA latches out_port into WDATA and starts a write cycle.
- Write to RDREQ starts a read cycle (data ignored).
- Write to STATUS has no effect.
- Read-back, registered every cycle from dir[1:0]:
  - 01 -> RDATA
  - 11 -> {6'b0, err, busy}
  - 00 -> ADDR
  - 10 -> 0
  - act_rtc = 0 -> 0
- A read_strobe with act_rtc = 1 and dir[1:0] = 11 clears err at that edge; the value already presented still shows the old err.
- Any write (ADDR/WDATA/RDREQ) while busy = 1 is ignored and sets err.
- writestrobe and read_strobe in the same cycle: the write is processed; the read side effect (err clear) is also applied.

FSM: IDLE -> A_SETUP -> A_STRB -> A_HOLD -> D_SETUP -> D_STRB -> D_HOLD -> IDLE
- busy = 1 in every state except IDLE. busy rises on the edge that accepts the command.
- Each state lasts exactly its parameter count, via a shared down-counter reloaded on each state entry.
- All A_* states: cs_n = 0, rtc_ad = 0, oe = 1, ad_out = ADDR; wr_n = 0 only in A_STRB.
- All D_* states: cs_n = 0, rtc_ad = 1.
  - Write cycle: oe = 1, ad_out = WDATA, wr_n = 0 in D_STRB.
  - Read cycle: oe = 0, rd_n = 0 in D_STRB; RDATA <= rtc_ad_in on the last D_STRB cycle.
- Total busy = 2*(SETUP_CYC+STROBE_CYC+HOLD_CYC) cycles (28 at defaults).
- A new command is accepted in the first IDLE cycle after busy falls.
- rd_n and wr_n are never low together.
- rtc_cs_n rises in the same cycle busy falls.
- All bus outputs are registered; no glitches.

Test Plan:
- Reset, then write ADDR = 0x21, WDATA = 0x45 -> busy for 28 cycles; wr_n low 10 cycles with ad = 0 and ad_out = 0x21, then 10 cycles with ad = 1 and ad_out = 0x45; cs_n low for all 28 cycles.
- Set ADDR = 0x22, write RDREQ, rtc_ad_in = 0x37 during D_STRB -> oe = 0 in the data phase; poll STATUS returns 0x01 until done; then RDATA read = 0x37.
- Write WDATA = 0x99 while busy -> bus unchanged, WDATA keeps its old value; STATUS reads 0x03; the next STATUS read returns 0x01 or 0x00 with err cleared.
- Writes with act_rtc = 0 to any dir -> no bus activity, registers unchanged, in_portRTC = 0.
- Assert kcpsm6_reset during D_STRB of a read -> cs_n, rd_n, wr_n go to 1 asynchronously; RDATA unchanged; a fresh command after reset runs the full 28-cycle cycle.
- Back-to-back: issue WDATA in the first cycle after busy falls -> accepted without err; no idle gap required.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_bus_ctrl
//
// Turns PicoBlaze port writes into timed, multiplexed address/data bus cycles
// toward an external RTC, and returns read data and status to the micro.
//
// Register map (dir[1:0], only when act_rtc = 1):
//   00 ADDR   : write latches the bus address;   read returns ADDR
//   01 WDATA  : write latches data, starts write; read returns RDATA
//   10 RDREQ  : write starts a read cycle;        read returns 0
//   11 STATUS : write has no effect;              read returns {6'b0, err, busy}
//               and a read strobe clears err.
//
// Every bus cycle is an address phase followed by a data phase, each made of
// SETUP_CYC + STROBE_CYC + HOLD_CYC clocks. Commands issued while busy are
// dropped and flag err.
//
// Ports:
//   clk          system clock, rising edge
//   kcpsm6_reset asynchronous active-high reset
//   act_rtc      decoder select for the RTC port range
//   dir          decoded local address (bits [1:0] used)
//   out_port     micro write data
//   writestrobe  micro write strobe (1-cycle pulse)
//   read_strobe  micro read strobe (1-cycle pulse)
//   in_portRTC   registered read-back to the micro
//   rtc_cs_n     RTC chip select, active low
//   rtc_rd_n     RTC read strobe, active low
//   rtc_wr_n     RTC write strobe, active low
//   rtc_ad       0 = address phase, 1 = data phase
//   rtc_ad_out   bus drive value
//   rtc_ad_oe    1 = drive the bus (tristate lives at the top level)
//   rtc_ad_in    sampled bus value
// -----------------------------------------------------------------------------
module rtc_bus_ctrl #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 10,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic       clk,
  input  logic       kcpsm6_reset,
  input  logic       act_rtc,
  input  logic [7:0] dir,
  input  logic [7:0] out_port,
  input  logic       writestrobe,
  input  logic       read_strobe,
  output logic [7:0] in_portRTC,
  output logic       rtc_cs_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic       rtc_ad,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in
);

  localparam int unsigned MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_STRB, A_HOLD, D_SETUP, D_STRB, D_HOLD
  } state_t;

  typedef enum logic [1:0] {
    REG_ADDR   = 2'b00,
    REG_DATA   = 2'b01,
    REG_RDREQ  = 2'b10,
    REG_STATUS = 2'b11
  } reg_sel_t;

  // Dwell time of each phase state, stored as count-1 so the state ends when
  // the shared down-counter reaches zero.
  function automatic cnt_t load_for(input state_t s);
    case (s)
      A_SETUP, D_SETUP: load_for = cnt_t'(SETUP_CYC - 1);
      A_STRB,  D_STRB:  load_for = cnt_t'(STROBE_CYC - 1);
      A_HOLD,  D_HOLD:  load_for = cnt_t'(HOLD_CYC - 1);
      default:          load_for = '0;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      A_SETUP: next_phase = A_STRB;
      A_STRB:  next_phase = A_HOLD;
      A_HOLD:  next_phase = D_SETUP;
      D_SETUP: next_phase = D_STRB;
      D_STRB:  next_phase = D_HOLD;
      default: next_phase = IDLE;
    endcase
  endfunction

  state_t   state_q, state_d;
  cnt_t     cnt_q, cnt_d;
  logic     rd_cycle_q, rd_cycle_d;
  logic [7:0] addr_q, wdata_q, rdata_q;
  logic     err_q;

  reg_sel_t sel;
  logic     busy;
  logic     wr_acc;
  logic     cmd_start;

  // Only the two low address bits select a register.
  logic     unused_dir;
  assign unused_dir = ^dir[7:2];

  assign sel       = reg_sel_t'(dir[1:0]);
  assign busy      = (state_q != IDLE);
  assign wr_acc    = act_rtc & writestrobe;
  assign cmd_start = wr_acc & ~busy & ((sel == REG_DATA) | (sel == REG_RDREQ));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_cycle_d = rd_cycle_q;

    if (state_q == IDLE) begin
      if (cmd_start) begin
        state_d    = A_SETUP;
        cnt_d      = load_for(A_SETUP);
        rd_cycle_d = (sel == REG_RDREQ);
      end
    end else if (cnt_q == '0) begin
      state_d = next_phase(state_q);
      cnt_d   = load_for(next_phase(state_q));
    end else begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge kcpsm6_reset) begin
    if (kcpsm6_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_cycle_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_cycle_q <= rd_cycle_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs: decoded from the *next* state and registered, so the pins
  // change together with the state and never glitch.
  // ---------------------------------------------------------------------------
  logic       cs_n_d, rd_n_d, wr_n_d, ad_d, oe_d;
  logic [7:0] ad_out_d;

  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_d     = 1'b0;
    oe_d     = 1'b0;
    ad_out_d = '0;
    case (state_d)
      A_SETUP, A_STRB, A_HOLD: begin
        cs_n_d   = 1'b0;
        oe_d     = 1'b1;
        ad_out_d = addr_q;
        wr_n_d   = (state_d != A_STRB);
      end
      D_SETUP, D_STRB, D_HOLD: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b1;
        if (rd_cycle_d) begin
          // Bus released so the RTC can drive it.
          rd_n_d = (state_d != D_STRB);
        end else begin
          oe_d     = 1'b1;
          ad_out_d = wdata_q;
          wr_n_d   = (state_d != D_STRB);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge kcpsm6_reset) begin
    if (kcpsm6_reset) begin
      rtc_cs_n   <= 1'b1;
      rtc_rd_n   <= 1'b1;
      rtc_wr_n   <= 1'b1;
      rtc_ad     <= 1'b0;
      rtc_ad_oe  <= 1'b0;
      rtc_ad_out <= '0;
    end else begin
      rtc_cs_n   <= cs_n_d;
      rtc_rd_n   <= rd_n_d;
      rtc_wr_n   <= wr_n_d;
      rtc_ad     <= ad_d;
      rtc_ad_oe  <= oe_d;
      rtc_ad_out <= ad_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Micro-visible registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge kcpsm6_reset) begin
    if (kcpsm6_reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (wr_acc && !busy) begin
      if (sel == REG_ADDR) addr_q  <= out_port;
      if (sel == REG_DATA) wdata_q <= out_port;
    end
  end

  // Read data is captured on the final clock of the data strobe.
  always_ff @(posedge clk or posedge kcpsm6_reset) begin
    if (kcpsm6_reset) begin
      rdata_q <= '0;
    end else if (state_q == D_STRB && cnt_q == '0 && rd_cycle_q) begin
      rdata_q <= rtc_ad_in;
    end
  end

  // Set and clear can never coincide: clearing needs dir = STATUS, while
  // setting needs a write to any other register.
  always_ff @(posedge clk or posedge kcpsm6_reset) begin
    if (kcpsm6_reset) begin
      err_q <= 1'b0;
    end else if (wr_acc && busy && sel != REG_STATUS) begin
      err_q <= 1'b1;
    end else if (act_rtc && read_strobe && sel == REG_STATUS) begin
      err_q <= 1'b0;
    end
  end

  // Read-back is refreshed every cycle, so STATUS shows err as it was before
  // the clearing edge.
  always_ff @(posedge clk or posedge kcpsm6_reset) begin
    if (kcpsm6_reset) begin
      in_portRTC <= '0;
    end else if (!act_rtc) begin
      in_portRTC <= '0;
    end else begin
      case (sel)
        REG_ADDR:   in_portRTC <= addr_q;
        REG_DATA:   in_portRTC <= rdata_q;
        REG_STATUS: in_portRTC <= {6'b0, err_q, busy};
        default:    in_portRTC <= '0;
      endcase
    end
  end

endmodule
